// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer for a K=3, 4-state Viterbi decoder.
// Drives ACS stepping, metric init/normalisation and traceback handoff.
module viterbi_frame_ctrl #(
    parameter int PM_W        = 3,
    parameter int CNT_W       = 8,
    parameter int NORM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [PM_W-1:0]  min_metric,
    output logic             acs_en,
    output logic             pm_init,
    output logic             norm_en,
    output logic             tb_start,
    input  logic             tb_busy,
    input  logic             tb_done,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             frame_done,
    output logic             len_err,
    output logic             sat_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TB_WAIT,
        S_TB_RUN,
        S_DONE
    } state_t;

    localparam logic [PM_W-1:0] THRESH = PM_W'(NORM_THRESH);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] step_nxt;
    logic             can_start;
    logic             start_ok;
    logic             start_zero;
    logic             accept;

    assign can_start  = (state == S_IDLE) || (state == S_DONE);
    assign start_ok   = can_start & start & ~abort & (frame_len != '0);
    assign start_zero = can_start & start & ~abort & (frame_len == '0);

    // abort withdraws ready so a symbol offered that cycle is never consumed
    assign sym_ready  = (state == S_RUN) & ~abort;
    assign accept     = sym_ready & sym_valid;
    assign acs_en     = accept;
    assign norm_en    = accept & (min_metric >= THRESH);
    assign pm_init    = (state == S_INIT);
    assign tb_start   = (state == S_TB_WAIT) & ~tb_busy & ~abort;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE) & ~abort;
    assign step_nxt   = step_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            step_cnt <= '0;
            sat_err  <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            len_err <= start_zero;
            if (accept && (min_metric == '1))
                sat_err <= 1'b1;
            if (accept)
                step_cnt <= step_nxt;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start_ok) begin
                            len_q    <= frame_len;
                            step_cnt <= '0;
                            sat_err  <= 1'b0;
                            state    <= S_INIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_INIT:
                        state <= S_RUN;
                    S_RUN:
                        if (accept && (step_nxt == len_q))
                            state <= S_TB_WAIT;
                    S_TB_WAIT:
                        if (!tb_busy)
                            state <= S_TB_RUN;
                    S_TB_RUN:
                        if (tb_done)
                            state <= S_DONE;
                    default:
                        state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
